ct_spsram_2048x32_ctrl: RTL and testbench
=========================================

Name: ct_spsram_2048x32_ctrl

Overview:
Initiator-side controller for the 2048x32 single-port SRAM macro wrapper. It converts a valid/ready request channel (read/write, byte enables) into the macro's active-low pin protocol (CEN/GWEN/WEN/A/D). It captures Q one cycle after each read and returns read data on a buffered valid/ready response channel. After reset it zero-fills the array before accepting traffic; a software-triggered re-init is also supported.

Parameters:
ADDR_WIDTH, 11, SRAM address width (depth = 2^ADDR_WIDTH)
DATA_WIDTH, 32, SRAM data width; must be a multiple of 8
RSP_DEPTH, 3, response buffer entries; 3 is the minimum for one read per cycle under rsp_rdy=1
INIT_EN, 1, 1 = zero-fill on reset and on init_req; 0 = enter RUN directly

Ports:
forever_cpuclk  in  1  sole clock; also clocks the SRAM macro
cpurst_b  in  1  reset, synchronous, active-low
init_req  in  1  pulse; requests a re-init, taken only in RUN
init_done  out  1  high in RUN
req_vld  in  1  request valid
req_rdy  out  1  request ready
req_wr  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  word address
req_wdata  in  DATA_WIDTH  write data
req_be  in  DATA_WIDTH/8  byte enables, active-high
rsp_vld  out  1  read data valid
rsp_rdy  in  1  consumer ready
rsp_rdata  out  DATA_WIDTH  read data
sram_cen  out  1  chip enable, active-low
sram_gwen  out  1  global write enable, active-low
sram_wen  out  DATA_WIDTH  bit write enables, active-low
sram_a  out  ADDR_WIDTH  address
sram_d  out  DATA_WIDTH  write data
sram_q  in  DATA_WIDTH  read data, valid the cycle after a read edge

Behaviour:
- FSM states: RST_IDLE, INIT, RUN. cpurst_b=0 at an edge forces RST_IDLE, init_cnt=0, rd_pend=0, buffer empty.
- RST_IDLE -> INIT next cycle if INIT_EN=1, otherwise -> RUN.
- INIT: one write per cycle with sram_cen=0, sram_gwen=0, sram_wen=all 0, sram_d=0, sram_a=init_cnt; init_cnt increments each cycle. At the last address (all ones) -> RUN. INIT lasts exactly 2^ADDR_WIDTH cycles.
- RUN: on init_req=1 with no access accepted that cycle and rd_pend=0 -> INIT with init_cnt=0. A pending init_req holds req_rdy=0 until the transfer is taken. The response buffer is not flushed.
- Reset values: init_done=0, req_rdy=0, rsp_vld=0, rsp_rdata=0, sram_cen=1, sram_gwen=1, sram_wen=all 1, sram_a=0, sram_d=0.
- req_rdy = (state==RUN) & ~init_req & (buf_cnt + rd_pend < RSP_DEPTH). The credit check does not count a same-cycle pop.
- SRAM pins in RUN are combinational from the request and gated by accept = req_vld & req_rdy:
  - sram_cen = ~accept
  - sram_gwen = ~(accept & req_wr)
  - sram_wen[8i+7:8i] = {8{~req_be[i]}}
  - sram_a = req_addr; sram_d = req_wdata
- When not accepting, sram_a and sram_d are don't-care; CEN must be 1.
- Write with req_be=0: legal. GWEN still goes 0, WEN is all 1, memory is unchanged, no response.
- Read accepted at edge N: rd_pend=1 after N; sram_q is sampled at edge N+1 into the buffer tail; rsp_vld=1 from cycle N+1+. Load-to-use latency is 2 cycles.
- Writes produce no response. Read responses return in request order.
- Response buffer is a FIFO of RSP_DEPTH entries with pointers that wrap modulo RSP_DEPTH. Push and pop in the same cycle are legal; count is unchanged. Overflow is impossible by the credit rule; an overflow is flagged by an assertion.
- rsp_rdata and rsp_vld stay stable while rsp_vld=1 & rsp_rdy=0.
- Reset mid-INIT or mid-read: pending data is discarded and the FSM restarts from RST_IDLE; array contents are undefined until INIT completes.

Decomposition:
- Shared package ct_spsram_ctrl_pkg: state enum {RST_IDLE, INIT, RUN}, function be2wen (byte enables -> active-low bit mask), localparams BE_WIDTH = DATA_WIDTH/8 and DEPTH = 1<<ADDR_WIDTH.
- One sub-module: ct_spsram_rsp_fifo (parameterised sync FIFO, push/pop/cnt, same synchronous active-low reset).

Test Plan:
- Reset release, INIT_EN=1 -> init_done rises exactly 2048 cycles after leaving RST_IDLE; every sram_a 0..2047 is written once with D=0 and WEN=0; req_rdy=0 throughout.
- Write addr 0x005, data 0xDEADBEEF, be=4'b1111; then read 0x005 -> rsp_rdata=0xDEADBEEF with rsp_vld 2 cycles after the read accept.
- Write 0x005 be=4'b0010 data 0x00005500, then read -> 0xDEAD55EF; a sram_wen pin check shows [15:8]=0 and all other bits 1.
- Back-to-back reads 0x000..0x00F with rsp_rdy=1 -> one accept per cycle, 16 in-order responses, no bubbles after the first.
- rsp_rdy=0 while issuing reads -> req_rdy drops after 3 outstanding reads; no data is lost; releasing rsp_rdy drains in order.
- init_req pulse in RUN mid-traffic, then cpurst_b=0 during INIT at init_cnt=100 -> FSM returns to RST_IDLE, rsp_vld=0, sram_cen=1; INIT restarts from address 0.

Source files
------------

// File: rtl/ct_spsram_ctrl_pkg.sv
// Shared types and helpers for the 2048x32 single-port SRAM controller.
// Default geometry lives here so the top and bench agree on it.
package ct_spsram_ctrl_pkg;

  localparam int ADDR_WIDTH_DFLT = 11;
  localparam int DATA_WIDTH_DFLT = 32;
  localparam int BE_WIDTH        = DATA_WIDTH_DFLT / 8;
  localparam int DEPTH           = 1 << ADDR_WIDTH_DFLT;

  typedef enum logic [1:0] {
    RST_IDLE,
    INIT,
    RUN
  } state_t;

  // Active-high byte enables to the macro's active-low per-bit write mask.
  function automatic logic [DATA_WIDTH_DFLT-1:0] be2wen(input logic [BE_WIDTH-1:0] be);
    logic [DATA_WIDTH_DFLT-1:0] m;
    m = '1;
    for (int i = 0; i < BE_WIDTH; i++) begin
      m[8*i +: 8] = {8{~be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/ct_spsram_rsp_fifo.sv
// Read-response buffer: sync FIFO, output valid same cycle as push lands (0-cycle fall-through not provided).
// Pops are ignored when empty; push with no room is prevented upstream by credits and flagged by assertion.
module ct_spsram_rsp_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst_b,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic [CW-1:0]    cnt,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_pop;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (cnt == '0);
  assign do_pop  = pop & ~empty;
  assign pop_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge forever_cpuclk) begin
    if (push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst_b && push && !do_pop) begin
      assert (cnt != CW'(DEPTH)) else $error("rsp fifo overflow");
    end
  end

endmodule

// File: rtl/ct_spsram_2048x32_ctrl.sv
// Valid/ready front end for the 2048x32 SP-SRAM macro; zero-fills on reset/init_req, read data 2 cycles after accept.
// req_rdy is withheld by response-buffer credits (buffered + in-flight reads) and while init_req is pending.
module ct_spsram_2048x32_ctrl
  import ct_spsram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DFLT,
  parameter int DATA_WIDTH = DATA_WIDTH_DFLT,
  parameter int RSP_DEPTH  = 3,
  parameter int INIT_EN    = 1,
  localparam int BE_W = DATA_WIDTH / 8,
  localparam int CW   = $clog2(RSP_DEPTH + 1)
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  init_req,
  output logic                  init_done,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [BE_W-1:0]       req_be,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  rd_pend;
  logic                  accept;
  logic [CW-1:0]         buf_cnt;
  logic                  buf_empty;

  assign init_done = (state == RUN);
  // Credit check ignores a same-cycle pop so the FIFO never has to bypass.
  assign req_rdy   = cpurst_b & (state == RUN) & ~init_req &
                     ((int'(buf_cnt) + int'(rd_pend)) < RSP_DEPTH);
  assign accept    = req_vld & req_rdy;
  assign rsp_vld   = ~buf_empty;

  always_comb begin
    state_nxt = state;
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    case (state)
      RST_IDLE: begin
        state_nxt = (INIT_EN != 0) ? INIT : RUN;
      end
      INIT: begin
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_wen  = '0;
        sram_a    = init_cnt;
        if (init_cnt == '1) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        sram_cen  = ~accept;
        sram_gwen = ~(accept & req_wr);
        sram_wen  = be2wen(req_be);
        sram_a    = req_addr;
        sram_d    = req_wdata;
        if (init_req && !accept && !rd_pend && (INIT_EN != 0)) begin
          state_nxt = INIT;
        end
      end
      default: state_nxt = RST_IDLE;
    endcase
    // Keep the macro quiet during the reset edge even if we were mid-access.
    if (!cpurst_b) begin
      sram_cen  = 1'b1;
      sram_gwen = 1'b1;
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      state    <= RST_IDLE;
      init_cnt <= '0;
      rd_pend  <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_pend <= accept & ~req_wr;
      if (state == INIT) begin
        init_cnt <= init_cnt + 1'b1;
      end else if (state_nxt == INIT) begin
        init_cnt <= '0;
      end
    end
  end

  ct_spsram_rsp_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .forever_cpuclk (forever_cpuclk),
    .cpurst_b       (cpurst_b),
    .push           (rd_pend),
    .push_dat       (sram_q),
    .pop            (rsp_rdy),
    .pop_dat        (rsp_rdata),
    .cnt            (buf_cnt),
    .empty          (buf_empty)
  );

endmodule

// File: tb/tb_ct_spsram_2048x32_ctrl.sv
// Directed bench for ct_spsram_2048x32_ctrl with a behavioural SP-SRAM macro model.
module tb_ct_spsram_2048x32_ctrl;
  import ct_spsram_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        cpurst_b;
  logic        init_req;
  logic        init_done;
  logic        req_vld;
  logic        req_rdy;
  logic        req_wr;
  logic [10:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [31:0] rsp_rdata;
  logic        sram_cen;
  logic        sram_gwen;
  logic [31:0] sram_wen;
  logic [10:0] sram_a;
  logic [31:0] sram_d;
  logic [31:0] sram_q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ct_spsram_2048x32_ctrl dut (
    .forever_cpuclk (clk),
    .cpurst_b       (cpurst_b),
    .init_req       (init_req),
    .init_done      (init_done),
    .req_vld        (req_vld),
    .req_rdy        (req_rdy),
    .req_wr         (req_wr),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_be         (req_be),
    .rsp_vld        (rsp_vld),
    .rsp_rdy        (rsp_rdy),
    .rsp_rdata      (rsp_rdata),
    .sram_cen       (sram_cen),
    .sram_gwen      (sram_gwen),
    .sram_wen       (sram_wen),
    .sram_a         (sram_a),
    .sram_d         (sram_d),
    .sram_q         (sram_q)
  );

  // Macro model: bit-masked write, Q registered on the read edge.
  logic [31:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
  end
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= mem[sram_a];
    end
  end

  typedef struct {
    logic        wr;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_wen;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expects to be called #1 after the edge that entered INIT.
  task automatic check_init(input string tag);
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_wen !== 32'h0 ||
          sram_d !== 32'h0 || sram_a !== 11'(i) || req_rdy !== 1'b0 || init_done !== 1'b0)
        bad++;
      tick();
    end
    chk({tag, "_pins"}, bad, 0);
    chk({tag, "_done"}, {31'b0, init_done}, 32'd1);
    chk({tag, "_rdy"}, {31'b0, req_rdy}, 32'd1);
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    req_vld   = 1'b1;
    req_wr    = v.wr;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_be    = v.be;
    #1;
    chk({tag, "_rdy"}, {31'b0, req_rdy}, 32'd1);
    chk({tag, "_cen"}, {31'b0, sram_cen}, 32'd0);
    chk({tag, "_gwen"}, {31'b0, sram_gwen}, v.wr ? 32'd0 : 32'd1);
    chk({tag, "_wen"}, sram_wen, v.exp_wen);
    chk({tag, "_a"}, {21'b0, sram_a}, {21'b0, v.addr});
    @(posedge clk);
    #1;
    req_vld = 1'b0;
    #1;
    chk({tag, "_idle_cen"}, {31'b0, sram_cen}, 32'd1);
    if (!v.wr) begin
      chk({tag, "_lat_vld0"}, {31'b0, rsp_vld}, 32'd0);
      @(posedge clk);
      #1;
      chk({tag, "_vld"}, {31'b0, rsp_vld}, 32'd1);
      chk({tag, "_rdata"}, rsp_rdata, v.exp_rdata);
    end
    tick();
    chk({tag, "_vld_after"}, {31'b0, rsp_vld}, 32'd0);
  endtask

  function automatic logic [31:0] exp_low(input int a);
    case (a)
      0:       return 32'h00A50000;
      5:       return 32'hDEAD55EF;
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    logic [10:0] bp_addr [5];
    logic [31:0] bp_exp [3];
    logic [31:0] held;
    int tx, rx, last, bubbles, stalls, acc, changes;

    vecs[0]  = '{1'b1, 11'h005, 32'hDEADBEEF, 4'b1111, 32'h00000000, 32'h0};
    vecs[1]  = '{1'b0, 11'h005, 32'h0,        4'b0000, 32'hFFFFFFFF, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 11'h005, 32'h00005500, 4'b0010, 32'hFFFF00FF, 32'h0};
    vecs[3]  = '{1'b0, 11'h005, 32'h0,        4'b0000, 32'hFFFFFFFF, 32'hDEAD55EF};
    vecs[4]  = '{1'b1, 11'h7FF, 32'h12345678, 4'b1001, 32'h00FFFF00, 32'h0};
    vecs[5]  = '{1'b0, 11'h7FF, 32'h0,        4'b0000, 32'hFFFFFFFF, 32'h12000078};
    vecs[6]  = '{1'b1, 11'h010, 32'hFFFFFFFF, 4'b0000, 32'hFFFFFFFF, 32'h0};
    vecs[7]  = '{1'b0, 11'h010, 32'h0,        4'b0000, 32'hFFFFFFFF, 32'h00000000};
    vecs[8]  = '{1'b0, 11'h000, 32'h0,        4'b0000, 32'hFFFFFFFF, 32'h00000000};
    vecs[9]  = '{1'b1, 11'h000, 32'hA5A5A5A5, 4'b0100, 32'hFF00FFFF, 32'h0};
    vecs[10] = '{1'b0, 11'h000, 32'h0,        4'b0000, 32'hFFFFFFFF, 32'h00A50000};

    cpurst_b = 1'b0; init_req = 1'b0; req_vld = 1'b0; req_wr = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0; rsp_rdy = 1'b1;
    tick(); tick();
    chk("rst_init_done", {31'b0, init_done}, 32'd0);
    chk("rst_req_rdy", {31'b0, req_rdy}, 32'd0);
    chk("rst_rsp_vld", {31'b0, rsp_vld}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_cen", {31'b0, sram_cen}, 32'd1);
    chk("rst_gwen", {31'b0, sram_gwen}, 32'd1);
    chk("rst_wen", sram_wen, 32'hFFFFFFFF);
    chk("rst_a", {21'b0, sram_a}, 32'h0);
    chk("rst_d", sram_d, 32'h0);

    cpurst_b = 1'b1;
    tick();
    check_init("init0");

    for (int i = 0; i < 11; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back reads with rsp_rdy=1.
    tx = 0; rx = 0; last = 0; bubbles = 0; stalls = 0;
    req_vld = 1'b1; req_wr = 1'b0; req_be = '0; req_addr = 11'd0;
    for (int c = 0; c < 40 && rx < 16; c++) begin
      #1;
      acc = (req_vld && req_rdy) ? 1 : 0;
      if (req_vld && !req_rdy) stalls++;
      tick();
      tx += acc;
      if (tx < 16) req_addr = 11'(tx);
      else         req_vld = 1'b0;
      if (rsp_vld) begin
        if (rx > 0 && c != last + 1) bubbles++;
        chk($sformatf("b2b_rdata%0d", rx), rsp_rdata, exp_low(rx));
        rx++;
        last = c;
      end
    end
    req_vld = 1'b0;
    chk("b2b_count", rx, 16);
    chk("b2b_bubbles", bubbles, 0);
    chk("b2b_stalls", stalls, 0);
    tick();

    // Backpressure: only three reads may be outstanding.
    bp_addr[0] = 11'h000; bp_addr[1] = 11'h005; bp_addr[2] = 11'h7FF;
    bp_addr[3] = 11'h001; bp_addr[4] = 11'h002;
    bp_exp[0] = 32'h00A50000; bp_exp[1] = 32'hDEAD55EF; bp_exp[2] = 32'h12000078;
    rsp_rdy = 1'b0; tx = 0; changes = 0; held = 32'h0;
    req_vld = 1'b1; req_addr = bp_addr[0];
    for (int c = 0; c < 8; c++) begin
      #1;
      acc = (req_vld && req_rdy) ? 1 : 0;
      tick();
      tx += acc;
      req_addr = bp_addr[tx];
      if (c == 2) held = rsp_rdata;
      if (c > 2 && rsp_rdata !== held) changes++;
    end
    chk("bp_accepts", tx, 3);
    #1;
    chk("bp_rdy_low", {31'b0, req_rdy}, 32'd0);
    chk("bp_vld_held", {31'b0, rsp_vld}, 32'd1);
    chk("bp_rdata_stable", changes, 0);
    req_vld = 1'b0;
    rsp_rdy = 1'b1;
    #1;
    rx = 0;
    for (int c = 0; c < 10 && rx < 3; c++) begin
      if (rsp_vld) begin
        chk($sformatf("bp_drain%0d", rx), rsp_rdata, bp_exp[rx]);
        rx++;
      end
      tick();
    end
    chk("bp_drain_count", rx, 3);
    chk("bp_empty", {31'b0, rsp_vld}, 32'd0);

    // init_req behind an in-flight read, then reset mid-INIT.
    req_vld = 1'b1; req_wr = 1'b0; req_addr = 11'h005; req_be = '0;
    #1;
    chk("ir_rdy", {31'b0, req_rdy}, 32'd1);
    @(posedge clk);
    #1;
    req_vld = 1'b0;
    init_req = 1'b1;
    #1;
    chk("ir_hold_rdy", {31'b0, req_rdy}, 32'd0);
    chk("ir_still_run", {31'b0, init_done}, 32'd1);
    tick();
    chk("ir_rsp_vld", {31'b0, rsp_vld}, 32'd1);
    chk("ir_rsp_rdata", rsp_rdata, 32'hDEAD55EF);
    chk("ir_run_pend", {31'b0, init_done}, 32'd1);
    tick();
    init_req = 1'b0;
    chk("ir_in_init", {31'b0, init_done}, 32'd0);
    chk("ir_init_a0", {21'b0, sram_a}, 32'h0);
    chk("ir_init_cen", {31'b0, sram_cen}, 32'd0);
    chk("ir_rsp_popped", {31'b0, rsp_vld}, 32'd0);
    repeat (100) tick();
    chk("ir_init_a100", {21'b0, sram_a}, 32'd100);
    cpurst_b = 1'b0;
    tick();
    chk("mr_init_done", {31'b0, init_done}, 32'd0);
    chk("mr_rsp_vld", {31'b0, rsp_vld}, 32'd0);
    chk("mr_cen", {31'b0, sram_cen}, 32'd1);
    chk("mr_req_rdy", {31'b0, req_rdy}, 32'd0);
    chk("mr_a", {21'b0, sram_a}, 32'h0);
    cpurst_b = 1'b1;
    tick();
    check_init("init1");
    rv = '{1'b0, 11'h005, 32'h0, 4'b0000, 32'hFFFFFFFF, 32'h00000000};
    apply_vec(rv, "post_init_rd5");
    rv = '{1'b0, 11'h7FF, 32'h0, 4'b0000, 32'hFFFFFFFF, 32'h00000000};
    apply_vec(rv, "post_init_rd7ff");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
